// File: rtl/ahb_mbox_sender_if.sv
// AHB-lite bus bundle between the mailbox sender (master)
// and the shared matrix / mailbox slave.
interface ahb_mbox_sender_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic [A_WIDTH-1:0] haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [2:0]         hburst;
  logic [3:0]         hprot;
  logic [D_WIDTH-1:0] hwdata;
  logic [D_WIDTH-1:0] hrdata;
  logic               hready;
  logic [1:0]         hresp;

  modport master (
    output haddr, htrans, hwrite, hsize,
    output hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_mbox_sender.sv
// Mailbox initiator: buffers payload, polls the channel control
// word, writes payload into the mailbox RAM, then rings the doorbell.
module ahb_mbox_sender #(
  parameter int          A_WIDTH    = 32,
  parameter int          D_WIDTH    = 32,
  parameter logic [31:0] MBOX_BASE  = 32'h4000_0000,
  parameter int          CH         = 0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          POLL_MAX   = 1024,
  parameter int          POLL_GAP   = 8
) (
  input  logic               hclk,
  input  logic               hresetn,
  ahb_mbox_sender_if.master  bus,
  input  logic               wr_valid,
  input  logic [D_WIDTH-1:0] wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic [7:0]         msg_id,
  input  logic [14:0]        msg_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  localparam logic [A_WIDTH-1:0] CTRL_A =
    A_WIDTH'(MBOX_BASE + 32'(4 * CH));
  localparam logic [A_WIDTH-1:0] RAM_A =
    A_WIDTH'(MBOX_BASE + 32'h8000);
  localparam logic [PCW-1:0] PMAX = PCW'(POLL_MAX);
  localparam logic [GCW-1:0] GLAST = GCW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_GAP,
    S_WR_WAIT, S_WR_ADDR, S_WR_DATA,
    S_CTRL_ADDR, S_CTRL_DATA, S_ERR
  } state_t;

  state_t             state_q;
  logic [1:0]         htrans_q;
  logic [A_WIDTH-1:0] haddr_q;
  logic               hwrite_q;
  logic [D_WIDTH-1:0] hwdata_q;
  logic               busy_q, done_q, err_q;
  logic [1:0]         err_code_q;
  logic [7:0]         id_q;
  logic [14:0]        len_q;
  logic [13:0]        idx_q;
  logic [PCW-1:0]     poll_q;
  logic [GCW-1:0]     gap_q;

  logic [D_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]        wp_q, wp_d, rp_q, rp_d;
  logic               full, empty, push, pop, flush;

  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign empty = (wp_q == rp_q);
  assign wr_ready = !full;
  assign push  = wr_valid && !full;
  assign pop   = (state_q == S_WR_ADDR);
  assign flush = (state_q == S_ERR);

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (push) mem_q[wp_q[PW-1:0]] <= wr_data;
  end

  logic          bus_err;
  logic [13:0]   idx_nxt;
  logic [PCW-1:0] poll_nxt;

  assign bus_err  = (bus.hresp != 2'b00);
  assign idx_nxt  = idx_q + 14'd1;
  assign poll_nxt = (poll_q == PMAX) ? poll_q : poll_q + 1'b1;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      htrans_q   <= T_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      id_q       <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      poll_q     <= '0;
      gap_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          if (msg_len > 15'd8192) begin
            err_q      <= 1'b1;
            err_code_q <= 2'b11;
          end else begin
            id_q       <= msg_id;
            len_q      <= msg_len;
            busy_q     <= 1'b1;
            poll_q     <= '0;
            err_code_q <= 2'b00;
            state_q    <= S_RD_ADDR;
            htrans_q   <= T_NSEQ;
            haddr_q    <= CTRL_A;
            hwrite_q   <= 1'b0;
          end
        end
        S_RD_ADDR: begin
          htrans_q <= T_IDLE;
          state_q  <= S_RD_DATA;
        end
        S_RD_DATA: if (bus.hready) begin
          if (bus_err) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
          end else if (!bus.hrdata[30]) begin
            idx_q <= '0;
            if (len_q == 15'd0) begin
              state_q  <= S_CTRL_ADDR;
              htrans_q <= T_NSEQ;
              haddr_q  <= CTRL_A;
              hwrite_q <= 1'b1;
            end else begin
              state_q <= S_WR_WAIT;
            end
          end else begin
            poll_q <= poll_nxt;
            if (poll_nxt == PMAX) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end else begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GLAST) begin
            state_q  <= S_RD_ADDR;
            htrans_q <= T_NSEQ;
            haddr_q  <= CTRL_A;
            hwrite_q <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_WR_WAIT: if (!empty) begin
          state_q  <= S_WR_ADDR;
          htrans_q <= T_NSEQ;
          haddr_q  <= RAM_A + A_WIDTH'({idx_q, 2'b00});
          hwrite_q <= 1'b1;
        end
        S_WR_ADDR: begin
          htrans_q <= T_IDLE;
          hwdata_q <= mem_q[rp_q[PW-1:0]];
          state_q  <= S_WR_DATA;
        end
        S_WR_DATA: if (bus.hready) begin
          hwdata_q <= '0;
          if (bus_err) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
          end else begin
            idx_q <= idx_nxt;
            if ({1'b0, idx_nxt} == len_q) begin
              state_q  <= S_CTRL_ADDR;
              htrans_q <= T_NSEQ;
              haddr_q  <= CTRL_A;
              hwrite_q <= 1'b1;
            end else begin
              state_q <= S_WR_WAIT;
            end
          end
        end
        S_CTRL_ADDR: begin
          htrans_q <= T_IDLE;
          hwdata_q <= D_WIDTH'({2'b11, 7'b0, len_q, id_q});
          state_q  <= S_CTRL_DATA;
        end
        S_CTRL_DATA: if (bus.hready) begin
          hwdata_q <= '0;
          if (bus_err) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.haddr  = haddr_q;
  assign bus.htrans = htrans_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hsize  = 3'b010;
  assign bus.hburst = 3'b000;
  assign bus.hprot  = 4'b0011;
  assign bus.hwdata = hwdata_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
